// File: rtl/control_buffer_filas.sv
// Ping-pong write/read controller for the two-row line buffer feeding the filter.
// Optional row/frame counter and fin_cuadro port enabled by defining CONTADOR_FILAS_EN.
`timescale 1ns/1ps
module control_buffer_filas #(
    parameter int BITS_DATOS     = 8,
    parameter int ANCHO_FILA     = 640,
    parameter int BITS_DIRECCION = 10,
    parameter int ALTO_IMAGEN    = 480
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      entrada_valida,
    output logic                      listo_entrada,
    output logic                      escritura_1,
    output logic                      escritura_2,
    output logic [BITS_DIRECCION-1:0] direccion_escritura,
    output logic [BITS_DIRECCION-1:0] direccion_lectura,
    output logic                      seleccion,
    output logic                      salida_valida,
    input  logic                      listo_salida,
    output logic                      fin_fila
`ifdef CONTADOR_FILAS_EN
    ,
    output logic                      fin_cuadro
`endif
);

    localparam bit CONFIG_VALIDA = (BITS_DATOS > 0) && (ANCHO_FILA >= 2) &&
                                   ((2 ** BITS_DIRECCION) >= ANCHO_FILA) && (ALTO_IMAGEN > 0);
    localparam logic [BITS_DIRECCION-1:0] ULTIMA_COL = BITS_DIRECCION'(ANCHO_FILA - 1);

    generate
        if (!CONFIG_VALIDA) begin : g_config_invalida
            $error("control_buffer_filas: invalid parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        LEC_REPOSO,
        LEC_ACTIVA,
        LEC_ESPERA
    } estado_t;

    estado_t                   estado;
    logic                      banco_esc;
    logic                      banco_lec;
    logic [1:0]                lleno;
    logic [BITS_DIRECCION-1:0] col_esc;
    logic [BITS_DIRECCION-1:0] col_lec;

    logic       acepta;
    logic       fin_escritura;
    logic       emite;
    logic       entrega;
    logic       fin_lectura;
    logic [1:0] marca;
    logic [1:0] libera;

    always_comb begin
        listo_entrada       = !lleno[banco_esc];
        acepta              = entrada_valida && listo_entrada;
        escritura_1         = acepta && !banco_esc;
        escritura_2         = acepta && banco_esc;
        direccion_escritura = col_esc;
        fin_escritura       = acepta && (col_esc == ULTIMA_COL);
        emite               = (estado == LEC_ACTIVA) && (!salida_valida || listo_salida);
        entrega             = salida_valida && listo_salida;
        fin_lectura         = (estado == LEC_ESPERA) && entrega;
        marca               = '0;
        libera              = '0;
        if (fin_escritura) marca[banco_esc] = 1'b1;
        if (fin_lectura)   libera[banco_lec] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_esc   <= '0;
            banco_esc <= 1'b0;
        end else if (acepta) begin
            if (col_esc == ULTIMA_COL) begin
                col_esc   <= '0;
                banco_esc <= ~banco_esc;
            end else begin
                col_esc <= col_esc + 1'b1;
            end
        end
    end

    // lleno merges the write-side set and read-side clear so both land in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado            <= LEC_REPOSO;
            lleno             <= '0;
            banco_lec         <= 1'b0;
            col_lec           <= '0;
            direccion_lectura <= '0;
            seleccion         <= 1'b0;
            salida_valida     <= 1'b0;
            fin_fila          <= 1'b0;
        end else begin
            lleno    <= (lleno | marca) & ~libera;
            fin_fila <= fin_lectura;
            if (entrega && !emite) salida_valida <= 1'b0;
            case (estado)
                LEC_REPOSO: begin
                    if (lleno[banco_lec]) estado <= LEC_ACTIVA;
                end
                LEC_ACTIVA: begin
                    if (emite) begin
                        direccion_lectura <= col_lec;
                        seleccion         <= banco_lec;
                        salida_valida     <= 1'b1;
                        if (col_lec == ULTIMA_COL) begin
                            estado <= LEC_ESPERA;
                        end else begin
                            col_lec <= col_lec + 1'b1;
                        end
                    end
                end
                LEC_ESPERA: begin
                    if (entrega) begin
                        banco_lec <= ~banco_lec;
                        col_lec   <= '0;
                        estado    <= LEC_REPOSO;
                    end
                end
                default: estado <= LEC_REPOSO;
            endcase
        end
    end

`ifdef CONTADOR_FILAS_EN
    localparam int BITS_FILAS = (ALTO_IMAGEN > 1) ? $clog2(ALTO_IMAGEN) : 1;
    localparam logic [BITS_FILAS-1:0] ULTIMA_FILA = BITS_FILAS'(ALTO_IMAGEN - 1);

    logic [BITS_FILAS-1:0] contador_filas;

    always_ff @(posedge clk) begin
        if (reset) begin
            contador_filas <= '0;
            fin_cuadro     <= 1'b0;
        end else begin
            fin_cuadro <= 1'b0;
            if (fin_lectura) begin
                if (contador_filas == ULTIMA_FILA) begin
                    contador_filas <= '0;
                    fin_cuadro     <= 1'b1;
                end else begin
                    contador_filas <= contador_filas + 1'b1;
                end
            end
        end
    end
`endif

endmodule
